// File: rtl/filt_pkg.sv
// Shared constants and FSM state type for the coefficient MAC filter.
package filt_pkg;

    localparam int unsigned NTAPS  = 512;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned ACC_W  = 26;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned ADDR_W = $clog2(NTAPS);
    localparam int unsigned SHIFT  = ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/filt_mac.sv
// filt_mac: bit-steered multiply-accumulate over NTAPS coefficients.
// Each snapshot bit selects +coef (1) or -coef (0); the sum is scaled by
// 2^-SHIFT and saturated to OUT_W bits.
// Ports:
//   Clock, Reset     - rising-edge clock, asynchronous active-high reset
//   Start, Bits      - request and bitstream snapshot (latched on Start in IDLE)
//   CoefAddr         - coefficient read address (0 outside FETCH)
//   CoefData         - signed coefficient, one cycle after CoefAddr
//   Busy, Push, Dout - in-progress flag, result strobe, held filtered result
module filt_mac
    import filt_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [NTAPS-1:0]  Bits,
    output logic [ADDR_W-1:0] CoefAddr,
    input  logic [COEF_W-1:0] CoefData,
    output logic              Busy,
    output logic [OUT_W-1:0]  Dout,
    output logic              Push
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic [NTAPS-1:0]          snap_q, snap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]          dout_q, dout_d;
    logic                      busy_q, push_q;

    logic [ADDR_W-1:0]         tap_idx;
    logic signed [ACC_W-1:0]   coef_ext;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shr;
    logic [OUT_W-1:0]          dout_sat;

    // Datapath: CoefData belongs to the address issued last cycle; in DRAIN
    // the counter is back at 0, so cnt-1 wraps to the final tap.
    always_comb begin
        tap_idx  = cnt_q - ADDR_W'(1);
        coef_ext = ACC_W'($signed(CoefData));
        term     = snap_q[tap_idx] ? coef_ext : -coef_ext;
        acc_sum  = acc_q + term;
        acc_shr  = acc_sum >>> SHIFT;
        if (acc_shr > SAT_MAX) begin
            dout_sat = OUT_W'(SAT_MAX);
        end else if (acc_shr < SAT_MIN) begin
            dout_sat = OUT_W'(SAT_MIN);
        end else begin
            dout_sat = acc_shr[OUT_W-1:0];
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    snap_d  = Bits;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // No coefficient has returned yet in the first FETCH cycle.
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                end
                if (cnt_q == ADDR_W'(NTAPS - 1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                acc_d   = acc_sum;
                dout_d  = dout_sat;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            busy_q  <= (state_d != IDLE);
            push_q  <= (state_d == DONE);
        end
    end

    assign CoefAddr = cnt_q;
    assign Busy     = busy_q;
    assign Push     = push_q;
    assign Dout     = dout_q;

endmodule

// File: tb/tb_filt_mac.sv
// Self-checking bench for filt_mac: coefficient ROM model plus a
// sum-of-signed-terms reference computed with plain integer arithmetic.
module tb_filt_mac;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic [511:0]  Bits;
    logic [8:0]    CoefAddr;
    logic [15:0]   CoefData;
    logic          Busy;
    logic [15:0]   Dout;
    logic          Push;

    logic signed [15:0] coef_mem [512];
    logic [15:0]        prev_dout;
    int                 n_cmp;
    int                 n_fail;

    filt_mac dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Bits     (Bits),
        .CoefAddr (CoefAddr),
        .CoefData (CoefData),
        .Busy     (Busy),
        .Dout     (Dout),
        .Push     (Push)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous coefficient memory: data one cycle after the address.
    always @(posedge Clock) CoefData <= coef_mem[CoefAddr];

    // Reference: signed sum, floor-divide by 512, clamp to 16-bit signed.
    function automatic logic [15:0] model_dout(input logic [511:0] b);
        longint sum;
        longint q;
        sum = 0;
        for (int k = 0; k < 512; k++) begin
            if (b[k]) sum += longint'(coef_mem[k]);
            else      sum -= longint'(coef_mem[k]);
        end
        q = sum / 512;
        if ((sum % 512 != 0) && (sum < 0)) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [511:0] rand_bits();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic fill_coef_const(input logic signed [15:0] v);
        for (int k = 0; k < 512; k++) coef_mem[k] = v;
    endtask

    task automatic fill_coef_rand();
        for (int k = 0; k < 512; k++) coef_mem[k] = 16'($urandom);
    endtask

    // Runs one transaction starting in the current cycle (called #1 after an
    // edge). Returns in cycle T+515, where a back-to-back Start is legal.
    task automatic run_txn(input logic [511:0] b, input string name, input bit disturb);
        logic [15:0] exp_dout;
        int          push_cnt;
        int          push_cyc;
        logic [15:0] push_val;
        int          addr_err;
        logic        busy_514;
        logic        busy_515;
        logic [15:0] dout_513;
        logic [15:0] dout_515;
        exp_dout = model_dout(b);
        push_cnt = 0;
        push_cyc = -1;
        push_val = '0;
        addr_err = 0;
        busy_514 = 1'b0;
        busy_515 = 1'b1;
        dout_513 = '0;
        dout_515 = '0;
        Bits  = b;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int cyc = 1; cyc <= 515; cyc++) begin
            if (cyc <= 512 && CoefAddr !== 9'(cyc - 1)) addr_err++;
            if (cyc > 512 && CoefAddr !== 9'd0) addr_err++;
            if (Push === 1'b1) begin
                push_cnt++;
                push_cyc = cyc;
                push_val = Dout;
            end
            if (cyc == 513) dout_513 = Dout;
            if (cyc == 514) busy_514 = Busy;
            if (cyc == 515) begin
                busy_515 = Busy;
                dout_515 = Dout;
            end
            if (disturb) begin
                Bits  = rand_bits();
                Start = (cyc == 100) || (cyc == 514);
            end
            if (cyc < 515) begin
                @(posedge Clock); #1;
            end
        end
        Start = 1'b0;
        n_cmp++;
        if (push_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s push_count: got %0d expected 1", name, push_cnt);
        end
        n_cmp++;
        if (push_cyc !== 514) begin
            n_fail++;
            $display("FAIL %s push_cycle: got T+%0d expected T+514", name, push_cyc);
        end
        n_cmp++;
        if (push_val !== exp_dout) begin
            n_fail++;
            $display("FAIL %s dout: got %0d expected %0d", name, $signed(push_val), $signed(exp_dout));
        end
        n_cmp++;
        if (addr_err !== 0) begin
            n_fail++;
            $display("FAIL %s coef_addr_seq: %0d bad cycles expected 0", name, addr_err);
        end
        n_cmp++;
        if (busy_514 !== 1'b1 || busy_515 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_edges: got %b/%b at T+514/T+515 expected 1/0", name, busy_514, busy_515);
        end
        n_cmp++;
        if (dout_513 !== prev_dout || dout_515 !== exp_dout) begin
            n_fail++;
            $display("FAIL %s dout_hold: got %h/%h expected %h/%h", name, dout_513, dout_515, prev_dout, exp_dout);
        end
        prev_dout = exp_dout;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Bits  = '0;
        fill_coef_const(16'sd0);
        prev_dout = '0;
        repeat (3) @(posedge Clock);
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Push !== 1'b0 || Dout !== 16'h0000 || CoefAddr !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b push=%b dout=%h addr=%0d expected 0/0/0000/0",
                     Busy, Push, Dout, CoefAddr);
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_sum_ones();
        fill_coef_const(16'sd1);
        run_txn({512{1'b1}}, "all_ones_coef1", 1'b0);
        run_txn({512{1'b0}}, "all_zeros_coef1", 1'b0);
    endtask

    task automatic test_saturation();
        fill_coef_const(16'sd32767);
        run_txn({512{1'b1}}, "max_pos", 1'b0);
        fill_coef_const(-16'sd32768);
        run_txn({512{1'b0}}, "sat_pos_2p24", 1'b0);
        run_txn({512{1'b1}}, "min_neg", 1'b0);
    endtask

    task automatic test_ramp();
        logic [511:0] b;
        for (int k = 0; k < 512; k++) coef_mem[k] = 16'(k);
        b    = '0;
        b[0] = 1'b1;
        run_txn(b, "ramp_bit0", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            fill_coef_rand();
            run_txn(rand_bits(), "random", 1'b0);
        end
        for (int k = 0; k < 512; k++) coef_mem[k] = 16'($urandom_range(32767, 20000));
        run_txn(rand_bits() | rand_bits() | rand_bits(), "random_biased", 1'b0);
    endtask

    task automatic test_ignore_start();
        fill_coef_rand();
        run_txn(rand_bits(), "ignore_start", 1'b1);
    endtask

    task automatic test_back_to_back();
        fill_coef_rand();
        run_txn(rand_bits(), "b2b_first", 1'b0);
        run_txn(rand_bits(), "b2b_second", 1'b0);
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_coef_rand();
        Bits  = rand_bits();
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (299) @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Push !== 1'b0 || Dout !== 16'h0000 || CoefAddr !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got busy=%b push=%b dout=%h addr=%0d expected 0/0/0000/0",
                     Busy, Push, Dout, CoefAddr);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            if (Busy !== 1'b0 || Push !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_held: %0d cycles with busy/push set, expected 0", bad);
        end
        Reset     = 1'b0;
        prev_dout = '0;
        run_txn(rand_bits(), "after_reset", 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_sum_ones();
        test_saturation();
        test_ramp();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so a stuck run still terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
